seg_scan_ctrl: RTL

//   Parametrised multiplexed 7-segment display driver for N hex digits.

---
 rtl/seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex 7-segment display driver.
// One digit slot per SCAN_DIV clocks; inputs are latched once per frame so a
// whole scan always shows a coherent value. Outputs are registered and the
// drive polarity of both the digit selects and the segment byte is set by
// parameters.
module seg_scan_ctrl #(
    parameter int DIGITS          = 4,
    parameter int SCAN_DIV        = 25000,
    parameter int BLINK_DIV       = 250,
    parameter int COM_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_HIGH = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  En,
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [7:0]            dig_data,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FC_W  = $clog2(BLINK_DIV + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(BLINK_DIV - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{COM_ACTIVE_LOW != 0}};
    localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;

    // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Digits k>0 whose nibble and every higher nibble are zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] data);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen = seen | (data[4*k +: 4] != 4'h0);
            m[k] = (k != 0) && !seen;
        end
        return m;
    endfunction

    function automatic logic [7:0] seg_polarity(input logic [7:0] raw);
        return (SEG_ACTIVE_HIGH != 0) ? raw : ~raw;
    endfunction

    function automatic logic [DIGITS-1:0] sel_polarity(input logic [DIGITS-1:0] onehot);
        return (COM_ACTIVE_LOW != 0) ? ~onehot : onehot;
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic                blink_ph_q, blink_ph_d;
    logic                en_q, en_d;
    logic                frame_done_q, frame_done_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blink_q, sh_blink_d;
    logic                sh_lz_q, sh_lz_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [7:0]          dig_data_q, dig_data_d;

    logic                tick;
    logic                wrap;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                cur_lz;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   lz_blank;
    logic                blank;
    logic [7:0]          raw_seg;

    // Prescaler, digit index, frame/blink counters and shadow capture.
    always_comb begin
        tick         = En && (cnt_q == CNT_LAST);
        wrap         = tick && (idx_q == IDX_LAST);
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        fc_d         = fc_q;
        blink_ph_d   = blink_ph_q;
        frame_done_d = 1'b0;
        en_d         = En;
        sh_data_d    = sh_data_q;
        sh_dp_d      = sh_dp_q;
        sh_blink_d   = sh_blink_q;
        sh_lz_d      = sh_lz_q;
        if (!En) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            cnt_d        = tick ? '0 : cnt_q + 1'b1;
            frame_done_d = wrap;
            if (tick) begin
                idx_d = wrap ? '0 : idx_q + 1'b1;
            end
            if (wrap) begin
                if (fc_q == FC_LAST) begin
                    fc_d       = '0;
                    blink_ph_d = ~blink_ph_q;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
        end
        // A new frame (or an idle display) picks up fresh inputs.
        if (wrap || !En) begin
            sh_data_d  = disp_data;
            sh_dp_d    = dp_mask;
            sh_blink_d = blink_mask;
            sh_lz_d    = blank_lz;
        end
    end

    // Decode the currently indexed digit from the shadow copy.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        onehot    = '0;
        lz_blank  = sh_lz_q ? lz_mask(sh_data_q) : '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = sh_data_q[4*k +: 4];
                cur_dp    = sh_dp_q[k];
                cur_blink = sh_blink_q[k];
                cur_lz    = lz_blank[k];
                onehot[k] = 1'b1;
            end
        end
        blank      = cur_lz || (blink_ph_q && cur_blink);
        raw_seg    = blank ? 8'h00 : {cur_dp, hex_to_seg(cur_nib)};
        dig_sel_d  = en_q ? sel_polarity(onehot) : SEL_OFF;
        dig_data_d = en_q ? seg_polarity(raw_seg) : SEG_OFF;
    end

    // State and output registers; reset returns the display to dark.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            fc_q         <= '0;
            blink_ph_q   <= 1'b0;
            en_q         <= 1'b0;
            frame_done_q <= 1'b0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blink_q   <= '0;
            sh_lz_q      <= 1'b0;
            dig_sel_q    <= SEL_OFF;
            dig_data_q   <= SEG_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            fc_q         <= fc_d;
            blink_ph_q   <= blink_ph_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_blink_q   <= sh_blink_d;
            sh_lz_q      <= sh_lz_d;
            dig_sel_q    <= dig_sel_d;
            dig_data_q   <= dig_data_d;
        end
    end

    assign dig_sel    = dig_sel_q;
    assign dig_data   = dig_data_q;
    assign frame_done = frame_done_q;

endmodule
